// File: rtl/inst_memory.sv
// Purpose: 16x8 writable instruction store; streams a program in over a valid/ready port while holding the core in reset.
// Latency: inst is a combinational read of mem[pc]; a byte accepted at edge N is readable from edge N+1 (once in RUN).
// Backpressure: none inside LOAD (load_ready stays high); load_ready is low in IDLE and RUN. Option macro: INST_MEM_BOOT_IMAGE_EN.
module inst_memory #(
  parameter int LOAD_LEN = 16
) (
  input  logic       clk_cpu,
  input  logic       reset,
  input  logic [3:0] pc,
  output logic [7:0] inst,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  output logic       load_done,
  output logic       cpu_reset
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ADDR = 4'(LOAD_LEN - 1);

  state_t     state;
  logic [7:0] mem [16];
  logic [3:0] waddr;
  logic       accept;
  logic       last_accept;

  // load_start in the same cycle as a byte drops the byte
  assign accept      = (state == LOAD) && load_valid && load_ready && !load_start;
  assign last_accept = accept && (waddr == LAST_ADDR);

  // core only sees real instructions once released
  assign inst = (state == RUN) ? mem[pc] : 8'h00;

  // sequencing: state, write pointer and the registered handshake/reset outputs
  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      waddr      <= 4'd0;
      load_done  <= 1'b0;
      load_ready <= 1'b0;
`ifdef INST_MEM_BOOT_IMAGE_EN
      state      <= RUN;
      cpu_reset  <= 1'b1;
`else
      state      <= IDLE;
      cpu_reset  <= 1'b0;
`endif
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            waddr      <= 4'd0;
            load_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (load_start) begin
            waddr <= 4'd0;
          end else if (last_accept) begin
            // terminal byte: leave LOAD without advancing so waddr never wraps
            state      <= RUN;
            load_ready <= 1'b0;
            load_done  <= 1'b1;
            cpu_reset  <= 1'b1;
          end else if (accept) begin
            waddr <= waddr + 4'd1;
          end
        end
        RUN: begin
          if (load_start) begin
            state      <= LOAD;
            waddr      <= 4'd0;
            load_ready <= 1'b1;
            cpu_reset  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          waddr      <= 4'd0;
          load_ready <= 1'b0;
          cpu_reset  <= 1'b0;
        end
      endcase
    end
  end

  // storage: reset clears (or seeds the boot image); accepted bytes land at waddr
  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
`ifdef INST_MEM_BOOT_IMAGE_EN
        mem[i] <= {4'h0, 4'(i)};
`else
        mem[i] <= 8'h00;
`endif
      end
    end else if (accept) begin
      mem[waddr] <= load_data;
    end
  end

endmodule

// File: doc/inst_memory.md
# inst_memory

16×8 writable instruction store directly upstream of the 4-bit CPU core: it returns `inst` for the core's `pc` and owns the only path for putting a program into the machine. A byte-stream load port with a valid/ready handshake fills the store while the block holds the core in reset through `cpu_reset`. The core is released to run once the load completes.

## Interface
Parameters:
- `LOAD_LEN`, 16: bytes accepted per load, legal range 1..16; loaded into addresses 0..LOAD_LEN-1.

Ports:
- `clk_cpu`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state while low.
- `pc`  in  4  read address from the core.
- `inst`  out  8  instruction at `pc`.
- `load_start`  in  1  single-cycle request to begin (or restart) a load.
- `load_valid`  in  1  `load_data` is valid this cycle.
- `load_data`  in  8  program byte.
- `load_ready`  out  1  block accepts a byte this cycle.
- `load_done`  out  1  one-cycle pulse after the final byte is written.
- `cpu_reset`  out  1  active-low reset for the core; low holds the core.

## Operation
- Storage: `mem[0..15]`, 8 bits each, plus a 4-bit write address `waddr` and a 2-bit state register.
- States:
  - IDLE: core held.
  - LOAD: accepting bytes.
  - RUN: core released.
- Reset, macro off: state IDLE, `mem` all 8'h00, `waddr`=0, `load_done`=0, `cpu_reset`=0, `load_ready`=0, `inst`=8'h00.
- IDLE: `load_start`=1 → LOAD, `waddr`←0.
- LOAD:
  - `load_ready`=1.
  - A byte is accepted when `load_valid` & `load_ready` & !`load_start`: `mem[waddr]`←`load_data`, `waddr`←`waddr`+1.
  - The accept that writes address LOAD_LEN-1 → RUN and sets `load_done` for one cycle.
  - `load_start`=1 in LOAD restarts: `waddr`←0, no byte written that cycle, state stays LOAD.
- RUN:
  - `cpu_reset`=1.
  - `load_start`=1 → LOAD, `waddr`←0, `cpu_reset` low from the next cycle.
  - `load_valid` is ignored.
- `inst` = `mem[pc]` in RUN, 8'h00 in IDLE and LOAD. This combinational read feeds the core's decoder directly.
- Addresses ≥ LOAD_LEN keep their previous contents across loads. They are cleared only by reset.
- `waddr` never wraps past LOAD_LEN-1; the terminal accept leaves LOAD.

## Timing
- `cpu_reset`, `load_ready`, `load_done` are registered outputs derived from state.
- Write latency: a byte accepted at edge N is visible on `inst` at edge N+1, once in RUN and addressed by `pc`.
- Final accept at edge N:
  - state = RUN and `load_done`=1 during cycle N..N+1.
  - `cpu_reset`=1 from edge N; the core's first clock out of reset fetches `mem[0]`.
- Handshake: `load_ready` is high for the whole of LOAD, including the cycle the final byte is taken.
  - No backpressure inside LOAD.
  - The producer may hold `load_valid` low for any number of cycles.
- Reset asserted mid-load: contents written so far are discarded, and the block returns to its reset state asynchronously.
- `load_start` together with `load_valid` in the same cycle: `load_start` wins and the byte is dropped.

## Configuration
- `INST_MEM_BOOT_IMAGE_EN`:
  - Defined: reset loads `mem[i]` = {4'h0, i[3:0]} (8'h00..8'h0F) and enters RUN with `cpu_reset`=1, so the core runs the boot image without a load. `load_start` behaves as above.
  - Undefined: reset clears `mem` to 8'h00 and enters IDLE with the core held.

## Test plan
- Reset then a 16-byte load of 8'hA0..8'hAF with `load_valid` continuous:
  - `load_done` pulses once, 16 cycles after the first accept.
  - `cpu_reset` rises with it.
  - Sweeping `pc` 0..15 returns 8'hA0..8'hAF.
- Same load with `load_valid` deasserted on every other cycle: identical contents, `load_done` after 31 cycles.
- Restart mid-load:
  - Load 8'h11,8'h22,8'h33, then `load_start`, then 16 bytes of 8'h55.
  - `mem[0..15]`=8'h55; `load_done` pulses only once.
- Reset low asynchronously after 5 bytes: `cpu_reset`=0 and `inst`=8'h00 immediately; with the macro off, state is IDLE and all `mem`=8'h00.
- LOAD_LEN=4, after a prior 16-byte load of 8'hFF:
  - Load 8'h01..8'h04.
  - `pc` 0..3 → 8'h01..8'h04; `pc` 4..15 → 8'hFF.
- Macro defined: after reset, `cpu_reset`=1 with no stimulus, and `pc`=7 → `inst`=8'h07.
